// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types and constants for the fetch stage.
//
//   word_t         32-bit machine word (instructions and addresses)
//   fetch_state_t  fetch FSM encoding; HALTED exists only when
//                  FETCH_HALT_DETECT_EN is defined
//   HALT_INSTR     instruction word that stops fetch (halt detect builds)
//   pc_next()      sequential PC increment, wraps modulo 2^32
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1
`ifdef FETCH_HALT_DETECT_EN
        ,
        HALTED = 2'd2
`endif
    } fetch_state_t;

    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;
    localparam word_t PC_STEP    = 32'd4;

    // Plain 32-bit add: carry out is dropped, so 0xFFFFFFFC + 4 wraps to 0.
    function automatic word_t pc_next(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg -- IF/ID pipeline latch.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall                  hold all contents (ignored when flush is high)
//   flush                  clear valid next cycle; beats stall and wr
//   wr                     write {wr_valid, wr_instr, wr_npc} when not stalled
//   wr_valid/instr/npc     next contents; wr_valid=0 inserts a bubble
//   valid, instr, npc      registered latch contents handed to decode
module ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  logic  wr,
    input  logic  wr_valid,
    input  word_t wr_instr,
    input  word_t wr_npc,
    output logic  valid,
    output word_t instr,
    output word_t npc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            npc   <= '0;
        end else if (flush) begin
            // instr/npc are meaningless once valid drops, so leave them.
            valid <= 1'b0;
        end else if (wr && !stall) begin
            valid <= wr_valid;
            instr <= wr_instr;
            npc   <= wr_npc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch: PC register, fetch FSM and IF/ID latch.
//
// Build option: FETCH_HALT_DETECT_EN enables HALT detection (HALT_INSTR
// stops fetch in the HALTED state). Undefined: HALT is an ordinary word and
// fetch_halted is constant 0.
//
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   ihit, imemload                  icache hit and the word read this cycle
//   imemREN, imemaddr               icache read request and address (= PC)
//   stall, flush                    hazard unit hold / IF/ID squash
//   redirect, redirect_pc           taken branch/jump and its target
//   ifid_valid/instr/npc            IF/ID contents for decode
//   fetch_halted                    fetch stopped on HALT
//   state_dbg                       current FSM state, for observation
//
// Icache handshake: imemREN/imemaddr form the request and stay stable until
// the cycle ihit is high; ihit means imemload holds the word for imemaddr in
// that same cycle, and the word is consumed (or discarded) on that edge.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC0 = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         ihit,
    input  word_t        imemload,
    output logic         imemREN,
    output word_t        imemaddr,
    input  logic         stall,
    input  logic         flush,
    input  logic         redirect,
    input  word_t        redirect_pc,
    output logic         ifid_valid,
    output word_t        ifid_instr,
    output word_t        ifid_npc,
    output logic         fetch_halted,
    output fetch_state_t state_dbg
);

    fetch_state_t state;
    word_t        pc;
    word_t        saved_pc;
    word_t        pc_inc;

    logic ifid_wr;
    logic ifid_wr_valid;
    logic ifid_kill;

    assign pc_inc    = pc_next(pc);
    assign imemaddr  = pc;
    assign state_dbg = state;

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q;
    logic halt_word;
    assign halt_word    = (imemload == HALT_INSTR);
    assign fetch_halted = halted_q;
    assign imemREN      = (state != HALTED);
`else
    assign fetch_halted = 1'b0;
    assign imemREN      = 1'b1;
`endif

    // IF/ID control. Only an accepted fetch without redirect writes a valid
    // entry; any other FETCH/DRAIN cycle writes a bubble (the latch itself
    // ignores writes while stalled). A same-cycle redirect with a hit kills
    // IF/ID even under stall.
    always_comb begin
        ifid_wr       = 1'b0;
        ifid_wr_valid = 1'b0;
        ifid_kill     = flush;
        case (state)
            FETCH: begin
                ifid_wr       = 1'b1;
                ifid_wr_valid = ihit && !redirect;
                if (redirect && ihit) ifid_kill = 1'b1;
            end
            DRAIN: begin
                ifid_wr = 1'b1;
            end
`ifdef FETCH_HALT_DETECT_EN
            HALTED: begin
                // Keep the HALT visible; leaving on redirect means it was
                // a wrong-path HALT, so drop it.
                if (redirect) ifid_kill = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= FETCH;
            pc       <= PC0;
            saved_pc <= '0;
`ifdef FETCH_HALT_DETECT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (ihit) begin
                            pc <= redirect_pc;
                        end else begin
                            // Outstanding miss at the old PC must complete
                            // before the address may change.
                            saved_pc <= redirect_pc;
                            state    <= DRAIN;
                        end
                    end else if (ihit && !stall) begin
`ifdef FETCH_HALT_DETECT_EN
                        if (halt_word) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            pc <= pc_inc;
                        end
`else
                        pc <= pc_inc;
`endif
                    end
                end
                DRAIN: begin
                    if (ihit) begin
                        pc    <= redirect ? redirect_pc : saved_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        saved_pc <= redirect_pc;
                    end
                end
`ifdef FETCH_HALT_DETECT_EN
                HALTED: begin
                    if (redirect) begin
                        pc       <= redirect_pc;
                        halted_q <= 1'b0;
                        state    <= FETCH;
                    end
                end
`endif
                default: state <= FETCH;
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (CLK),
        .rst_n    (nRST),
        .stall    (stall),
        .flush    (ifid_kill),
        .wr       (ifid_wr),
        .wr_valid (ifid_wr_valid),
        .wr_instr (imemload),
        .wr_npc   (pc_inc),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .npc      (ifid_npc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Expected IF/ID contents are queued when each cycle's stimulus is issued
// and compared after the following rising edge.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t W1 = 32'h2001_0005;
    localparam word_t W2 = 32'h8C22_0004;
    localparam word_t W3 = 32'h0043_1820;

    logic         CLK;
    logic         nRST;
    logic         ihit;
    word_t        imemload;
    logic         imemREN;
    word_t        imemaddr;
    logic         stall;
    logic         flush;
    logic         redirect;
    word_t        redirect_pc;
    logic         ifid_valid;
    word_t        ifid_instr;
    word_t        ifid_npc;
    logic         fetch_halted;
    fetch_state_t state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [64:0] exp_q[$];

    fetch_stage #(.PC0(32'h0000_0000)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .imemload     (imemload),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_npc     (ifid_npc),
        .fetch_halted (fetch_halted),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive inputs at the falling edge, sample 1 ns after the
    // rising edge. ev/ei/en are the IF/ID contents required afterwards.
    task automatic step(input string name, input logic hit, input word_t word,
                        input logic stl, input logic fl, input logic rd,
                        input word_t rpc, input word_t exp_addr,
                        input logic ev, input word_t ei, input word_t en);
        logic [64:0] e;
        exp_q.push_back({ev, ei, en});
        @(negedge CLK);
        ihit        = hit;
        imemload    = word;
        stall       = stl;
        flush       = fl;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check({name, ".valid"}, {31'd0, ifid_valid}, {31'd0, e[64]});
        if (e[64]) begin
            check({name, ".instr"}, ifid_instr, e[63:32]);
            check({name, ".npc"}, ifid_npc, e[31:0]);
        end
        check({name, ".addr"}, imemaddr, exp_addr);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; imemload = '0; stall = 1'b0;
        flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #22;
        // Reset state
        check("rst.addr",   imemaddr, 32'h0);
        check("rst.ren",    {31'd0, imemREN}, 32'd1);
        check("rst.valid",  {31'd0, ifid_valid}, 32'd0);
        check("rst.instr",  ifid_instr, 32'h0);
        check("rst.npc",    ifid_npc, 32'h0);
        check("rst.halted", {31'd0, fetch_halted}, 32'd0);
        check("rst.state",  {30'd0, state_dbg}, {30'd0, FETCH});
        @(negedge CLK);
        nRST = 1'b1;

        // Sequential fetch
        step("seq0", 1, W1, 0, 0, 0, 0, 32'h4, 1, W1, 32'h4);
        step("seq1", 1, W1, 0, 0, 0, 0, 32'h8, 1, W1, 32'h8);
        // Stall with hits at PC=8
        for (int i = 0; i < 3; i++)
            step("stall", 1, W2, 1, 0, 0, 0, 32'h8, 1, W1, 32'h8);
        step("unstall", 1, W2, 0, 0, 0, 0, 32'hC, 1, W2, 32'hC);
        step("seq2", 1, W1, 0, 0, 0, 0, 32'h10, 1, W1, 32'h10);

        // Redirect during a miss at PC=16, hit two cycles later
        step("drn.rd",   0, W3, 0, 0, 1, 32'h40, 32'h10, 0, 0, 0);
        step("drn.wait", 0, W3, 0, 0, 0, 32'h0,  32'h10, 0, 0, 0);
        step("drn.hit",  1, W3, 0, 0, 0, 32'h0,  32'h40, 0, 0, 0);
        step("drn.res",  1, W1, 0, 0, 0, 32'h0,  32'h44, 1, W1, 32'h44);

        // Latest redirect wins while draining
        step("lw.rd1", 0, W3, 0, 0, 1, 32'h40, 32'h44, 0, 0, 0);
        step("lw.rd2", 0, W3, 0, 0, 1, 32'h80, 32'h44, 0, 0, 0);
        step("lw.hit", 1, W3, 0, 0, 0, 32'h0,  32'h80, 0, 0, 0);
        step("lw.res", 1, W2, 0, 0, 0, 32'h0,  32'h84, 1, W2, 32'h84);

        // Redirect with hit overrides stall
        step("rdst", 1, W3, 1, 0, 1, 32'h200, 32'h200, 0, 0, 0);
        step("rdst.f", 1, W3, 0, 0, 0, 32'h0, 32'h204, 1, W3, 32'h204);

        // Flush beats stall and load
        step("flush", 1, W1, 1, 1, 0, 32'h0, 32'h204, 0, 0, 0);

        // Miss: hold under stall, bubble otherwise
        step("miss.f",  1, W1, 0, 0, 0, 32'h0, 32'h208, 1, W1, 32'h208);
        step("miss.st", 0, W2, 1, 0, 0, 32'h0, 32'h208, 1, W1, 32'h208);
        step("miss.bb", 0, W2, 0, 0, 0, 32'h0, 32'h208, 0, 0, 0);

        // PC wrap
        step("wrap.rd", 1, W1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0);
        step("wrap",    1, W2, 0, 0, 0, 32'h0, 32'h0, 1, W2, 32'h0);

`ifdef FETCH_HALT_DETECT_EN
        step("h.rd",  1, W1, 0, 0, 1, 32'h18, 32'h18, 0, 0, 0);
        step("h.get", 1, HALT_INSTR, 0, 0, 0, 32'h0, 32'h18, 1, HALT_INSTR, 32'h1C);
        check("h.halted", {31'd0, fetch_halted}, 32'd1);
        check("h.ren",    {31'd0, imemREN}, 32'd0);
        step("h.idle", 1, W1, 0, 0, 0, 32'h0, 32'h18, 1, HALT_INSTR, 32'h1C);
        check("h.halted2", {31'd0, fetch_halted}, 32'd1);
        step("h.exit", 1, W1, 0, 0, 1, 32'h100, 32'h100, 0, 0, 0);
        check("h.unhalt", {31'd0, fetch_halted}, 32'd0);
        check("h.ren2",   {31'd0, imemREN}, 32'd1);
        step("h.res", 1, W3, 0, 0, 0, 32'h0, 32'h104, 1, W3, 32'h104);
`else
        step("h.plain", 1, HALT_INSTR, 0, 0, 0, 32'h0, 32'h4, 1, HALT_INSTR, 32'h4);
        check("h.halted", {31'd0, fetch_halted}, 32'd0);
        check("h.ren",    {31'd0, imemREN}, 32'd1);
`endif

        // Reset in the middle of a drain
        step("rr.rd",  1, W1, 0, 0, 1, 32'h500, 32'h500, 0, 0, 0);
        step("rr.drn", 0, W1, 0, 0, 1, 32'h300, 32'h500, 0, 0, 0);
        @(negedge CLK);
        ihit = 1'b0; redirect = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("rr.addr",  imemaddr, 32'h0);
        check("rr.valid", {31'd0, ifid_valid}, 32'd0);
        check("rr.ren",   {31'd0, imemREN}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        step("rr.res", 1, W2, 0, 0, 0, 32'h0, 32'h4, 1, W2, 32'h4);

        // Randomised sequential run: PC advances by 4 on every accepted hit
        begin
            word_t pc_m;
            word_t w;
            logic  h;
            pc_m = 32'h4;
            for (int i = 0; i < 20; i++) begin
                h = 1'($urandom_range(0, 1));
                w = $urandom;
                if (w == HALT_INSTR) w = W1;
                if (h) begin
                    pc_m = pc_m + 32'd4;
                    step("rnd", 1, w, 0, 0, 0, 32'h0, pc_m, 1, w, pc_m);
                end else begin
                    step("rnd", 0, w, 0, 0, 0, 32'h0, pc_m, 0, 0, 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
